// File: rtl/clock_timebase.sv
// clock_timebase: divides the system clock into a 1 Hz tick and keeps
// the second/minute/hour indices for the ammeter-clock needle drivers.
// A valid/ready load port sets the time; out-of-range requests are rejected.
`timescale 1ns/1ps

module clock_timebase #(
    parameter int SYSCLKHZ = 50_000_000,
    parameter int HOURS    = 12
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       En,
    input  logic       set_valid,
    input  logic [7:0] set_sec,
    input  logic [7:0] set_min,
    input  logic [7:0] set_hour,
    output logic       set_ready,
    output logic       set_ack,
    output logic       set_err,
    output logic [7:0] sec_data,
    output logic [7:0] min_data,
    output logic [7:0] hour_data,
    output logic       sec_tick,
    output logic       min_tick,
    output logic       hour_tick
);

    localparam int             PW        = $clog2(SYSCLKHZ);
    localparam logic [PW-1:0]  PRESC_TC  = PW'(SYSCLKHZ - 1);
    localparam logic [7:0]     MS_MAX    = 8'd59;
    localparam logic [7:0]     HOUR_MAX  = 8'(HOURS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic [PW-1:0] presc_r;
    logic [7:0]    sec_r;
    logic [7:0]    min_r;
    logic [7:0]    hour_r;
    logic          sec_tick_r;
    logic          min_tick_r;
    logic          hour_tick_r;
    logic          set_ready_r;
    logic          set_ack_r;
    logic          set_err_r;

    logic          in_range_s;
    logic          load_s;
    logic          reject_s;
    logic          tc_s;
    logic          sec_wrap_s;
    logic          min_wrap_s;
    logic          hour_wrap_s;

    // Request range check and terminal-count/wrap detection.
    always_comb begin
        in_range_s  = (set_sec <= MS_MAX) && (set_min <= MS_MAX) && (set_hour <= HOUR_MAX);
        sec_wrap_s  = (sec_r == MS_MAX);
        min_wrap_s  = (min_r == MS_MAX);
        hour_wrap_s = (hour_r == HOUR_MAX);
        if (En && (presc_r == PRESC_TC)) begin
            tc_s = 1'b1;
        end else begin
            tc_s = 1'b0;
        end
    end

    // Load-port FSM next state and accept/reject decode.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        reject_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (set_valid) begin
                    if (in_range_s) begin
                        load_s       = 1'b1;
                        next_state_s = ST_ACK;
                    end else begin
                        reject_s     = 1'b1;
                        next_state_s = ST_IDLE;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACK: begin
                // Requests arriving during the ack cycle are ignored.
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Load-port state register and registered handshake outputs.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_r     <= ST_IDLE;
            set_ready_r <= 1'b1;
            set_ack_r   <= 1'b0;
            set_err_r   <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            set_ready_r <= (next_state_s == ST_IDLE);
            set_ack_r   <= load_s;
            set_err_r   <= reject_s;
        end
    end

    // Prescaler and sec/min/hour cascade; an accepted load overrides a coincident tick.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            presc_r     <= '0;
            sec_r       <= 8'd0;
            min_r       <= 8'd0;
            hour_r      <= 8'd0;
            sec_tick_r  <= 1'b0;
            min_tick_r  <= 1'b0;
            hour_tick_r <= 1'b0;
        end else if (load_s) begin
            presc_r     <= '0;
            sec_r       <= set_sec;
            min_r       <= set_min;
            hour_r      <= set_hour;
            sec_tick_r  <= 1'b0;
            min_tick_r  <= 1'b0;
            hour_tick_r <= 1'b0;
        end else if (tc_s) begin
            presc_r     <= '0;
            sec_tick_r  <= 1'b1;
            min_tick_r  <= sec_wrap_s;
            hour_tick_r <= sec_wrap_s && min_wrap_s;
            if (sec_wrap_s) begin
                sec_r <= 8'd0;
                if (min_wrap_s) begin
                    min_r  <= 8'd0;
                    hour_r <= hour_wrap_s ? 8'd0 : (hour_r + 8'd1);
                end else begin
                    min_r <= min_r + 8'd1;
                end
            end else begin
                sec_r <= sec_r + 8'd1;
            end
        end else begin
            sec_tick_r  <= 1'b0;
            min_tick_r  <= 1'b0;
            hour_tick_r <= 1'b0;
            if (En) begin
                presc_r <= presc_r + PW'(1);
            end else begin
                presc_r <= presc_r;
            end
        end
    end

    assign set_ready = set_ready_r;
    assign set_ack   = set_ack_r;
    assign set_err   = set_err_r;
    assign sec_data  = sec_r;
    assign min_data  = min_r;
    assign hour_data = hour_r;
    assign sec_tick  = sec_tick_r;
    assign min_tick  = min_tick_r;
    assign hour_tick = hour_tick_r;

endmodule

// File: tb/tb_clock_timebase.sv
// Self-checking bench for clock_timebase with a 4-cycle second and a
// 12-hour dial. A reference model pushes expected outputs at each edge;
// they are popped and compared against the DUT on the following negedge.
`timescale 1ns/1ps

module tb_clock_timebase;

    localparam int SYSCLKHZ = 4;
    localparam int HOURS    = 12;

    logic       clk = 1'b0;
    logic       Rst;
    logic       En;
    logic       set_valid;
    logic [7:0] set_sec;
    logic [7:0] set_min;
    logic [7:0] set_hour;
    logic       set_ready;
    logic       set_ack;
    logic       set_err;
    logic [7:0] sec_data;
    logic [7:0] min_data;
    logic [7:0] hour_data;
    logic       sec_tick;
    logic       min_tick;
    logic       hour_tick;

    clock_timebase #(.SYSCLKHZ(SYSCLKHZ), .HOURS(HOURS)) dut (
        .clk       (clk),
        .Rst       (Rst),
        .En        (En),
        .set_valid (set_valid),
        .set_sec   (set_sec),
        .set_min   (set_min),
        .set_hour  (set_hour),
        .set_ready (set_ready),
        .set_ack   (set_ack),
        .set_err   (set_err),
        .sec_data  (sec_data),
        .min_data  (min_data),
        .hour_data (hour_data),
        .sec_tick  (sec_tick),
        .min_tick  (min_tick),
        .hour_tick (hour_tick)
    );

    always #5 clk = ~clk;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];
    string       phase = "reset";

    // Reference model state
    int          m_presc, m_sec, m_min, m_hour;
    bit          m_inack;
    logic [31:0] m_out;

    function automatic logic [31:0] pack(input logic rdy, input logic ack, input logic err,
                                         input logic st, input logic mt, input logic ht,
                                         input int h, input int m, input int s);
        logic [7:0] h8, m8, s8;
        h8 = 8'(h); m8 = 8'(m); s8 = 8'(s);
        return {2'b00, rdy, ack, err, st, mt, ht, h8, m8, s8};
    endfunction

    function automatic logic [31:0] dut_out();
        return {2'b00, set_ready, set_ack, set_err, sec_tick, min_tick, hour_tick,
                hour_data, min_data, sec_data};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_presc = 0; m_sec = 0; m_min = 0; m_hour = 0; m_inack = 1'b0;
        m_out = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit acc, rej, st, mt, ht;
        acc = 1'b0; rej = 1'b0; st = 1'b0; mt = 1'b0; ht = 1'b0;
        if (!m_inack && set_valid) begin
            if (set_sec <= 59 && set_min <= 59 && int'(set_hour) < HOURS) acc = 1'b1;
            else rej = 1'b1;
        end
        if (acc) begin
            m_sec = set_sec; m_min = set_min; m_hour = set_hour; m_presc = 0;
        end else if (En) begin
            if (m_presc == SYSCLKHZ - 1) begin
                m_presc = 0;
                st = 1'b1;
                m_sec = m_sec + 1;
                if (m_sec == 60) begin
                    m_sec = 0; mt = 1'b1; m_min = m_min + 1;
                    if (m_min == 60) begin
                        m_min = 0; ht = 1'b1; m_hour = (m_hour + 1) % HOURS;
                    end
                end
            end else begin
                m_presc = m_presc + 1;
            end
        end
        m_inack = acc;
        m_out = pack(!acc, acc, rej, st, mt, ht, m_hour, m_min, m_sec);
        exp_q.push_back(m_out);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_eq({phase, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            check_eq(phase, dut_out(), exp_q.pop_front());
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Assert reset mid-cycle, check the asynchronous effect, release at a negedge.
    task automatic do_reset();
        Rst = 1'b1;
        #1;
        model_reset();
        check_eq({phase, "_rst_async"}, dut_out(), m_out);
        @(negedge clk);
        check_eq({phase, "_rst_hold"}, dut_out(), m_out);
        Rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic load(input int h, input int m, input int s);
        set_valid = 1'b1;
        set_hour = 8'(h); set_min = 8'(m); set_sec = 8'(s);
        step();
        set_valid = 1'b0;
    endtask

    logic [31:0] held;

    initial begin
        Rst = 1'b1; En = 1'b1; set_valid = 1'b0;
        set_sec = 8'd0; set_min = 8'd0; set_hour = 8'd0;
        do_reset();

        // Free run from reset: one minute elapses after 240 cycles.
        phase = "run";
        steps(240);
        check_eq("run_240", dut_out(), pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 0));

        // Full dial wrap.
        phase = "wrap";
        load(11, 59, 58);
        check_eq("wrap_load", dut_out(), pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11, 59, 58));
        steps(4);
        check_eq("wrap_59", dut_out(), pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11, 59, 59));
        steps(4);
        check_eq("wrap_00", dut_out(), pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 0));

        // Load with prescaler at 2; next tick 4 cycles after the load edge.
        phase = "load";
        steps(2);
        load(7, 30, 5);
        check_eq("load_ack", dut_out(), pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7, 30, 5));
        step();
        check_eq("load_rdy", dut_out(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 30, 5));
        steps(2);
        check_eq("load_notick", {31'd0, sec_tick}, 32'd0);
        step();
        check_eq("load_tick4", dut_out(), pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7, 30, 6));

        // Rejects: minute 60 then hour 12.
        phase = "reject";
        held = {8'd0, hour_data, min_data, sec_data};
        load(3, 60, 0);
        check_eq("rej_min_err", {29'd0, set_ready, set_ack, set_err}, 32'd5);
        check_eq("rej_min_val", {8'd0, hour_data, min_data, sec_data}, held);
        held = {8'd0, hour_data, min_data, sec_data};
        load(12, 0, 0);
        check_eq("rej_hr_err", {29'd0, set_ready, set_ack, set_err}, 32'd5);
        check_eq("rej_hr_val", {8'd0, hour_data, min_data, sec_data}, held);
        step();

        // Valid held through ACK is ignored for the ack cycle.
        phase = "hold_valid";
        set_valid = 1'b1; set_hour = 8'd1; set_min = 8'd2; set_sec = 8'd3;
        steps(3);
        set_valid = 1'b0;
        steps(2);

        // Collision: request sampled on the terminal-count edge.
        phase = "collide";
        for (int i = 0; i < 2 * SYSCLKHZ && m_presc != SYSCLKHZ - 1; i++) step();
        load(9, 10, 3);
        check_eq("coll_val", dut_out(), pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9, 10, 3));
        steps(4);
        check_eq("coll_next", dut_out(), pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9, 10, 4));

        // Enable freeze mid-count, then resume; also a load while frozen.
        phase = "enable";
        steps(2);
        En = 1'b0;
        held = {8'd0, hour_data, min_data, sec_data};
        steps(10);
        check_eq("en_hold", {8'd0, hour_data, min_data, sec_data}, held);
        En = 1'b1;
        steps(9);
        En = 1'b0;
        load(5, 5, 5);
        steps(6);
        check_eq("en_load_hold", dut_out(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5, 5, 5));
        En = 1'b1;
        steps(6);

        // Reset asserted during the ack cycle.
        phase = "rst_ack";
        load(3, 4, 5);
        #2;
        do_reset();
        phase = "post_rst";
        step();
        check_eq("post_rst_rdy", {31'd0, set_ready}, 32'd1);
        steps(8);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clock_timebase.md
# clock_timebase

Timekeeping stage feeding the ammeter-clock needle drivers. Divides the system clock into a 1 Hz tick and maintains second, minute and hour counters. Each counter is presented as an 8-bit binary index for the per-needle LUT + PWM stages, whose `time_data` inputs connect directly to `sec_data`, `min_data` and `hour_data`. A valid/ready load port sets the time from the button/UART front end.

## Interface
- `SYSCLKHZ`, 5000_0000: system clock frequency in Hz; the prescaler terminal count is SYSCLKHZ-1 (≥ 2).
- `HOURS`, 12: hour modulus; the hour counter runs 0..HOURS-1 (legal 2..24).
- `clk`  in  1  system clock.
- `Rst`  in  1  asynchronous, active-high reset.
- `En`  in  1  run enable; 0 freezes the prescaler and all counters.
- `set_valid`  in  1  load request.
- `set_sec`  in  8  requested second value.
- `set_min`  in  8  requested minute value.
- `set_hour`  in  8  requested hour value.
- `set_ready`  out  1  load port can accept a request.
- `set_ack`  out  1  one-cycle pulse: load applied.
- `set_err`  out  1  one-cycle pulse: load rejected (out of range).
- `sec_data`  out  8  seconds, 0..59.
- `min_data`  out  8  minutes, 0..59.
- `hour_data`  out  8  hours, 0..HOURS-1.
- `sec_tick`  out  1  one-cycle pulse on each second increment.
- `min_tick`  out  1  one-cycle pulse on each minute increment.
- `hour_tick`  out  1  one-cycle pulse on each hour increment.

## Operation
- Reset (async, while Rst=1): prescaler=0; sec/min/hour=0; all tick, ack and err outputs 0; set_ready=1; FSM=IDLE.
- Prescaler: width $clog2(SYSCLKHZ). When En=1 it increments; at SYSCLKHZ-1 it wraps to 0 and raises an internal tick. When En=0 it holds.
- Tick cascade, all on the same edge:
  - sec increments; at 59 it wraps to 0 and carries.
  - A carry increments min; at 59 it wraps to 0 and carries.
  - A carry increments hour; at HOURS-1 it wraps to 0.
- All arithmetic is unsigned 8-bit. Upper bits of the outputs are always 0 within the legal range.
- FSM states:
  - IDLE: set_ready=1. On set_valid=1:
    - If set_sec≤59, set_min≤59 and set_hour≤HOURS-1: load all three counters, clear the prescaler to 0, go to ACK.
    - Otherwise: assert set_err for one cycle, stay in IDLE, leave the counters unchanged.
  - ACK: set_ready=0, set_ack=1 for exactly one cycle, then return to IDLE unconditionally. set_valid is ignored in ACK.
- Simultaneous accepted load and prescaler terminal count: the load wins. The tick is discarded and no tick pulses are issued that cycle.
- Loads are accepted regardless of En. With En=0 the loaded value holds until En returns to 1.
- Reset mid-operation (including while in ACK) returns everything to the reset values immediately. No pending ack or err survives.

## Timing
- Outputs are registered. sec_data/min_data/hour_data update on the clock edge at which the prescaler wraps.
- sec_tick, min_tick and hour_tick are high in the cycle following that edge, coincident with the new values. At 59:59 → 00:00 all three ticks are high together.
- Tick period is exactly SYSCLKHZ clk cycles while En=1.
- Load latency:
  - Request sampled at edge N (set_valid=1, set_ready=1).
  - New values and set_ack are visible after edge N; set_ready is 0 in that same cycle.
  - set_ready returns to 1 after edge N+1.
- Reject latency: set_err is high in the cycle after the sampling edge; set_ready stays 1.
- After a load, the first second tick occurs SYSCLKHZ cycles after the load edge.
- Deasserting En freezes the prescaler mid-count. Reasserting it resumes from the held count, with no lost or extra tick.

## Test plan
- Reset/run: SYSCLKHZ=4, HOURS=12, En=1 from reset → sec_tick every 4 cycles; sec_data steps 0,1,2…; after 240 cycles min_data=1, sec_data=0, with min_tick and sec_tick coincident.
- Full wrap: load 11:59:58, run 2 ticks → 11:59:59, then 00:00:00 with sec_tick, min_tick and hour_tick high in the same cycle.
- Load handshake: assert set_valid with 5/30/7 while the prescaler is at 2 → set_ack one cycle, set_ready low one cycle, outputs 07:30:05, next sec_tick 4 cycles after the load edge.
- Reject: set_min=60 (and separately set_hour=12 with HOURS=12) → set_err one cycle, counters unchanged, set_ack never asserted.
- Collision: set_valid sampled on the exact terminal-count edge → loaded value appears unincremented and no sec_tick is issued that cycle.
- En/reset: drop En for 10 cycles mid-count → no ticks, values hold, period resumes correctly. Assert Rst during ACK → all outputs go to reset values asynchronously and set_ready=1 after release.
